// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, jump, relative branch, call/return via a LIFO stack.
// Optional macro PC_BOUND_EN adds a PC_LIMIT range check with a one-cycle o_bound_err pulse.
module pc_seq_unit #(
    parameter int unsigned          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
    parameter int unsigned          STK_DEPTH = 4,
    parameter int unsigned          STK_PTR_W = 3
`ifdef PC_BOUND_EN
    ,
    parameter logic [ADDR_W-1:0]    PC_LIMIT  = '1
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_restart,
    input  logic                 i_hold,
    input  logic                 i_jump,
    input  logic                 i_branch,
    input  logic                 i_call,
    input  logic                 i_ret,
    input  logic [ADDR_W-1:0]    i_target,
    input  logic [ADDR_W-1:0]    i_offset,
    output logic [ADDR_W-1:0]    o_pc,
    output logic [STK_PTR_W-1:0] o_stk_depth,
    output logic                 o_stk_ovf,
    output logic                 o_stk_unf
`ifdef PC_BOUND_EN
    ,
    output logic                 o_bound_err
`endif
);

    localparam int unsigned          IDX_W    = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam logic [STK_PTR_W-1:0] STK_FULL = STK_PTR_W'(STK_DEPTH);

    logic [ADDR_W-1:0]    pc_q, pc_d, pc_inc, pc_calc;
    logic [STK_PTR_W-1:0] depth_q, depth_d, top_ptr;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 push;
    logic [ADDR_W-1:0]    stk_q [STK_DEPTH];
    logic [ADDR_W-1:0]    stk_top;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign top_ptr = depth_q - STK_PTR_W'(1);
    assign stk_top = stk_q[top_ptr[IDX_W-1:0]];

    always_comb begin
        pc_calc = pc_inc;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (i_ret) begin
            if (depth_q != '0) begin
                pc_calc = stk_top;
                depth_d = top_ptr;
            end else begin
                unf_d = 1'b1;
            end
        end else if (i_call) begin
            pc_calc = i_target;
            if (depth_q < STK_FULL) begin
                push    = 1'b1;
                depth_d = depth_q + STK_PTR_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (i_jump) begin
            pc_calc = i_target;
        end else if (i_branch) begin
            pc_calc = pc_q + i_offset;
        end
    end

    // Restart and hold override the action decode above; the stack write is squashed with them.
    logic push_en;
    logic bound_d;

    always_comb begin
        pc_d    = pc_calc;
        push_en = push;
        bound_d = 1'b0;
`ifdef PC_BOUND_EN
        if (pc_calc > PC_LIMIT) begin
            pc_d    = RESET_VEC;
            bound_d = 1'b1;
        end
`endif
        if (i_restart || i_hold) begin
            push_en = 1'b0;
            bound_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (i_restart) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!i_hold) begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents need no reset; only the depth counter defines validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_q[depth_q[IDX_W-1:0]] <= pc_inc;
        end
    end

`ifdef PC_BOUND_EN
    logic bound_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bound_q <= 1'b0;
        end else begin
            bound_q <= bound_d;
        end
    end

    assign o_bound_err = bound_q;
`else
    logic unused_bound;
    assign unused_bound = bound_d;
`endif

    assign o_pc        = pc_q;
    assign o_stk_depth = depth_q;
    assign o_stk_ovf   = ovf_q;
    assign o_stk_unf   = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios then random requests,
// compared against a queue-based reference model of the sequencer.
module tb_pc_seq_unit;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned STK_DEPTH = 4;
    localparam int unsigned STK_PTR_W = 3;
    localparam logic [ADDR_W-1:0] RV  = 8'h10;
    localparam int MOD = 1 << ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 i_restart = 1'b0, i_hold = 1'b0, i_jump = 1'b0;
    logic                 i_branch = 1'b0, i_call = 1'b0, i_ret = 1'b0;
    logic [ADDR_W-1:0]    i_target = '0, i_offset = '0;
    logic [ADDR_W-1:0]    o_pc;
    logic [STK_PTR_W-1:0] o_stk_depth;
    logic                 o_stk_ovf, o_stk_unf;
`ifdef PC_BOUND_EN
    logic                 o_bound_err;
`endif

    pc_seq_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(RV),
        .STK_DEPTH(STK_DEPTH),
        .STK_PTR_W(STK_PTR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_restart  (i_restart),
        .i_hold     (i_hold),
        .i_jump     (i_jump),
        .i_branch   (i_branch),
        .i_call     (i_call),
        .i_ret      (i_ret),
        .i_target   (i_target),
        .i_offset   (i_offset),
        .o_pc       (o_pc),
        .o_stk_depth(o_stk_depth),
        .o_stk_ovf  (o_stk_ovf),
        .o_stk_unf  (o_stk_unf)
`ifdef PC_BOUND_EN
        ,
        .o_bound_err(o_bound_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers and a queue used as the return stack.
    int m_pc = int'(RV);
    int m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(o_pc),        32'(m_pc));
        check({tag, ".depth"}, 32'(o_stk_depth), 32'(m_stk.size()));
        check({tag, ".ovf"},   32'(o_stk_ovf),   32'(m_ovf));
        check({tag, ".unf"},   32'(o_stk_unf),   32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = int'(RV);
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step();
        if (i_restart) begin
            model_reset();
        end else if (i_hold) begin
            // nothing changes
        end else if (i_ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = (m_pc + 1) % MOD;
                m_unf = 1;
            end
        end else if (i_call) begin
            if (m_stk.size() < STK_DEPTH) m_stk.push_back((m_pc + 1) % MOD);
            else m_ovf = 1;
            m_pc = int'(i_target);
        end else if (i_jump) begin
            m_pc = int'(i_target);
        end else if (i_branch) begin
            m_pc = (m_pc + int'(i_offset)) % MOD;
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endtask

    // Called at a falling edge: drive, clock, update model, check 1 time unit after the edge.
    task automatic step(input string tag, input bit rs, input bit hd, input bit rt, input bit cl,
                        input bit jp, input bit br, input logic [ADDR_W-1:0] tgt,
                        input logic [ADDR_W-1:0] off);
        i_restart = rs; i_hold = hd; i_ret = rt; i_call = cl;
        i_jump = jp; i_branch = br; i_target = tgt; i_offset = off;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic jump(input string tag, input logic [ADDR_W-1:0] tgt);
        step(tag, 0, 0, 0, 0, 1, 0, tgt, '0);
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        idle("inc1"); idle("inc2"); idle("inc3");

        jump("to_ff", 8'hFF);
        idle("wrap_ff");

        jump("to_40", 8'h40);
        step("hold_jump", 0, 1, 0, 0, 1, 0, 8'h80, '0);
        step("restart_hold", 1, 1, 0, 0, 0, 0, '0, '0);

        jump("to_05", 8'h05);
        step("br_neg", 0, 0, 0, 0, 0, 1, '0, 8'hFA);
        jump("to_fe", 8'hFE);
        step("br_pos", 0, 0, 0, 0, 0, 1, '0, 8'h03);

        jump("to_20", 8'h20);
        step("call1", 0, 0, 0, 1, 0, 0, 8'h50, '0);
        step("call2", 0, 0, 0, 1, 0, 0, 8'h70, '0);
        step("ret1", 0, 0, 1, 0, 0, 0, '0, '0);
        step("ret2", 0, 0, 1, 0, 0, 0, '0, '0);

        for (int i = 0; i < 5; i++) step("call_n", 0, 0, 0, 1, 0, 0, 8'(8'h30 + 16 * i), '0);
        for (int i = 0; i < 5; i++) step("ret_n", 0, 0, 1, 0, 0, 0, '0, '0);
        step("restart_clr", 1, 0, 0, 0, 0, 0, '0, '0);

        // Asynchronous reset in the middle of a sequence.
        step("pre_rst_call", 0, 0, 0, 1, 0, 0, 8'h9A, '0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle("post_rst");

        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer; next generation of the CPU's 8-bit PC.
- Adds configurable address width and reset vector, sequential increment, absolute jump, signed relative branch, and call/return through an internal return-address stack with overflow/underflow flags.
- Sits between the instruction decoder/ALU branch logic and instruction memory address input.

Parameters:
- ADDR_W, 8, PC and target width in bits (≥4).
- RESET_VEC, 0, PC value after reset or restart (ADDR_W bits).
- STK_DEPTH, 4, return-stack entries (1..16).
- STK_PTR_W, 3, depth-counter width; must satisfy 2^STK_PTR_W > STK_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- i_restart  in  1  synchronous program restart (load program).
- i_hold  in  1  freeze PC (instruction done / stall).
- i_jump  in  1  absolute jump to i_target.
- i_branch  in  1  relative branch: PC + i_offset.
- i_call  in  1  push return address, jump to i_target.
- i_ret  in  1  pop return address into PC.
- i_target  in  ADDR_W  jump/call destination.
- i_offset  in  ADDR_W  two's-complement branch offset.
- o_pc  out  ADDR_W  current PC (registered).
- o_stk_depth  out  STK_PTR_W  valid stack entries.
- o_stk_ovf  out  1  sticky: call attempted while stack full.
- o_stk_unf  out  1  sticky: ret attempted while stack empty.

Behaviour:
- Reset (rst=0, async): o_pc=RESET_VEC, o_stk_depth=0, o_stk_ovf=0, o_stk_unf=0; stack contents don't-care.
- All updates on rising clk; one-cycle latency from request to new o_pc. No combinational input-to-output paths.
- Per-cycle priority (exactly one action): restart > hold > ret > call > jump > branch > increment.
- restart: o_pc=RESET_VEC, depth=0, both sticky flags cleared.
- hold: o_pc, stack, flags unchanged; lower-priority requests ignored and not remembered.
- ret, depth>0: o_pc=top entry, depth-1.
- ret, depth=0: o_pc=o_pc+1, o_stk_unf set, depth stays 0.
- call, depth<STK_DEPTH: push (o_pc+1) mod 2^ADDR_W, depth+1, o_pc=i_target.
- call, depth=STK_DEPTH: no push, depth unchanged, o_pc=i_target, o_stk_ovf set.
- jump: o_pc=i_target.
- branch: o_pc=(o_pc+i_offset) mod 2^ADDR_W (wraps both directions).
- no request: o_pc=(o_pc+1) mod 2^ADDR_W; max value wraps to 0.
- Stack is LIFO; entry index = depth-1 is top. Entries only written on successful push.
- Sticky flags remain set until restart or reset.
- rst asserted mid-operation overrides everything immediately; deassertion resumes incrementing from RESET_VEC on next edge.

Optional Feature:
- Macro PC_BOUND_EN.
- Defined: adds parameter PC_LIMIT (default 2^ADDR_W-1) and output o_bound_err (1 bit, reset 0). Any computed next PC (increment, branch, jump, call, ret) > PC_LIMIT instead loads RESET_VEC and pulses o_bound_err high for exactly one cycle; stack push/pop of that cycle still occur.
- Not defined: no PC_LIMIT check, no o_bound_err port; all wrap-around purely modulo 2^ADDR_W.

Test Plan:
- Reset/increment: ADDR_W=8, RESET_VEC=0x10, release rst, 3 idle cycles -> o_pc 0x10,0x11,0x12,0x13; from 0xFF idle -> 0x00.
- Hold/restart priority: o_pc=0x40, i_hold=1 with i_jump=1,i_target=0x80 -> o_pc stays 0x40; i_restart=1 with i_hold=1 -> o_pc=RESET_VEC next cycle.
- Branch wrap: o_pc=0x05, i_offset=0xFA (-6) -> o_pc=0xFF; o_pc=0xFE, i_offset=0x03 -> 0x01.
- Nested call/ret: at 0x20 call 0x50, at 0x50 call 0x70, ret, ret -> o_pc 0x50,0x70,0x51,0x21; depth 1,2,1,0.
- Stack limits: STK_DEPTH=4, five calls -> depth=4, fifth call still jumps, o_stk_ovf=1; five rets -> 4 pops correct, fifth increments, o_stk_unf=1; restart clears both flags.
- PC_BOUND_EN, PC_LIMIT=0x7F: jump to 0x90 -> o_pc=RESET_VEC, o_bound_err high exactly one cycle; increment 0x7E->0x7F no error.
